// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: pin function codes and register indices.
package gpio_pkg;

  localparam int unsigned ADDR_W = 3;
  localparam int unsigned FSEL_W = 2;

  typedef enum logic [FSEL_W-1:0] {
    FSEL_GPIO    = 2'b00,
    FSEL_ALT_IN  = 2'b01,
    FSEL_ALT_OUT = 2'b10,
    FSEL_IRQ     = 2'b11
  } fsel_e;

  localparam logic [ADDR_W-1:0] REG_DIR      = 3'd0;
  localparam logic [ADDR_W-1:0] REG_DOUT     = 3'd1;
  localparam logic [ADDR_W-1:0] REG_DIN      = 3'd2;
  localparam logic [ADDR_W-1:0] REG_IRQ_EN   = 3'd3;
  localparam logic [ADDR_W-1:0] REG_IRQ_EDGE = 3'd4;
  localparam logic [ADDR_W-1:0] REG_PEND     = 3'd5;
  localparam logic [ADDR_W-1:0] REG_DOUT_SET = 3'd6;
  localparam logic [ADDR_W-1:0] REG_DOUT_CLR = 3'd7;

endpackage

// File: rtl/gpio_pin_sync.sv
// Per-pin input synchroniser with a one-cycle history flop for edge detection.
module gpio_pin_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain;
  logic                   prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
      prev  <= 1'b0;
    end else begin
      chain <= {chain[SYNC_STAGES-2:0], pin};
      prev  <= chain[SYNC_STAGES-1];
    end
  end

  assign sync = chain[SYNC_STAGES-1];
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/gpio_ctrl.sv
// Clocked GPIO pin mux with register bus, synchronised inputs and sticky edge interrupts.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int unsigned NPINS       = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPINS-1:0]     pin_in,
  output logic [NPINS-1:0]     pin_out,
  output logic [NPINS-1:0]     pin_oe,
  input  logic [2*NPINS-1:0]   pinsel,
  input  logic [NPINS-1:0]     alt_out,
  output logic [NPINS-1:0]     alt_in,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [ADDR_W-1:0]    addr,
  input  logic [NPINS-1:0]     wdata,
  output logic [NPINS-1:0]     rdata,
  output logic                 rvalid,
  output logic                 irq
);

  logic [NPINS-1:0] dir_q, dout_q, irq_en_q, irq_edge_q, pend_q;
  logic [NPINS-1:0] sync, rise, fall;
  logic [NPINS-1:0] is_irq, w1c, pend_set, pend_d, rd_mux;

  for (genvar k = 0; k < NPINS; k++) begin : g_pin
    gpio_pin_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .pin  (pin_in[k]),
      .sync (sync[k]),
      .rise (rise[k]),
      .fall (fall[k])
    );
  end

  // Pad-side mux; alt_out passes straight through with no register stage.
  always_comb begin
    pin_oe  = '0;
    pin_out = '0;
    alt_in  = '0;
    is_irq  = '0;
    for (int k = 0; k < NPINS; k++) begin
      case (fsel_e'(pinsel[2*k +: 2]))
        FSEL_GPIO: begin
          pin_oe[k]  = dir_q[k];
          pin_out[k] = dout_q[k];
        end
        FSEL_ALT_IN:  alt_in[k] = sync[k];
        FSEL_ALT_OUT: begin
          pin_oe[k]  = 1'b1;
          pin_out[k] = alt_out[k];
        end
        FSEL_IRQ:     is_irq[k] = 1'b1;
      endcase
    end
  end

  // A new event in the same cycle as its W1C keeps the bit set.
  always_comb begin
    w1c      = (wr_en && (addr == REG_PEND)) ? wdata : '0;
    pend_set = is_irq & irq_en_q & ((rise & ~irq_edge_q) | (fall & irq_edge_q));
    pend_d   = (pend_q & ~w1c) | pend_set;
  end

  always_comb begin
    rd_mux = '0;
    case (addr)
      REG_DIR:      rd_mux = dir_q;
      REG_DOUT:     rd_mux = dout_q;
      REG_DIN:      rd_mux = sync;
      REG_IRQ_EN:   rd_mux = irq_en_q;
      REG_IRQ_EDGE: rd_mux = irq_edge_q;
      REG_PEND:     rd_mux = pend_q;
      default:      rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q      <= '0;
      dout_q     <= '0;
      irq_en_q   <= '0;
      irq_edge_q <= '0;
      pend_q     <= '0;
      irq        <= 1'b0;
      rdata      <= '0;
      rvalid     <= 1'b0;
    end else begin
      if (wr_en) begin
        case (addr)
          REG_DIR:      dir_q      <= wdata;
          REG_DOUT:     dout_q     <= wdata;
          REG_IRQ_EN:   irq_en_q   <= wdata;
          REG_IRQ_EDGE: irq_edge_q <= wdata;
          REG_DOUT_SET: dout_q     <= dout_q | wdata;
          REG_DOUT_CLR: dout_q     <= dout_q & ~wdata;
          default:      ;
        endcase
      end
      pend_q <= pend_d;
      irq    <= |(pend_q & irq_en_q);
      rvalid <= rd_en;
      if (rd_en) rdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed bench for gpio_ctrl: register table vectors plus timed mux/interrupt/reset sequences.
module tb_gpio_ctrl;

  localparam int unsigned NPINS = 16;

  logic              clk;
  logic              rst_n;
  logic [NPINS-1:0]  pin_in;
  logic [NPINS-1:0]  pin_out;
  logic [NPINS-1:0]  pin_oe;
  logic [2*NPINS-1:0] pinsel;
  logic [NPINS-1:0]  alt_out;
  logic [NPINS-1:0]  alt_in;
  logic              wr_en;
  logic              rd_en;
  logic [2:0]        addr;
  logic [NPINS-1:0]  wdata;
  logic [NPINS-1:0]  rdata;
  logic              rvalid;
  logic              irq;

  int checks;
  int failures;

  typedef struct {
    bit          rd;
    logic [2:0]  a;
    logic [15:0] data;
    logic [15:0] oe;
    logic [15:0] out;
  } vec_t;

  vec_t vecs[19];

  gpio_ctrl #(.NPINS(NPINS), .SYNC_STAGES(2)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .pin_in (pin_in),
    .pin_out(pin_out),
    .pin_oe (pin_oe),
    .pinsel (pinsel),
    .alt_out(alt_out),
    .alt_in (alt_in),
    .wr_en  (wr_en),
    .rd_en  (rd_en),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .rvalid (rvalid),
    .irq    (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] exp, input string name);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    chk({name, "_rvalid"}, 32'(rvalid), 32'd1);
    chk(name, 32'(rdata), 32'(exp));
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_pin_oe"},  32'(pin_oe),  32'd0);
    chk({tag, "_pin_out"}, 32'(pin_out), 32'd0);
    chk({tag, "_alt_in"},  32'(alt_in),  32'd0);
    chk({tag, "_rdata"},   32'(rdata),   32'd0);
    chk({tag, "_rvalid"},  32'(rvalid),  32'd0);
    chk({tag, "_irq"},     32'(irq),     32'd0);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_n = 1'b1; pin_in = '0; pinsel = '0; alt_out = '0;
    wr_en = 1'b0; rd_en = 1'b0; addr = '0; wdata = '0;

    vecs[0]  = '{1'b0, 3'd0, 16'h00FF, 16'h00FF, 16'h0000};
    vecs[1]  = '{1'b0, 3'd1, 16'h00A5, 16'h00FF, 16'h00A5};
    vecs[2]  = '{1'b1, 3'd0, 16'h00FF, 16'h00FF, 16'h00A5};
    vecs[3]  = '{1'b0, 3'd6, 16'h0100, 16'h00FF, 16'h01A5};
    vecs[4]  = '{1'b0, 3'd7, 16'h0001, 16'h00FF, 16'h01A4};
    vecs[5]  = '{1'b1, 3'd1, 16'h01A4, 16'h00FF, 16'h01A4};
    vecs[6]  = '{1'b0, 3'd2, 16'h1234, 16'h00FF, 16'h01A4};
    vecs[7]  = '{1'b1, 3'd2, 16'h0000, 16'h00FF, 16'h01A4};
    vecs[8]  = '{1'b1, 3'd6, 16'h0000, 16'h00FF, 16'h01A4};
    vecs[9]  = '{1'b1, 3'd7, 16'h0000, 16'h00FF, 16'h01A4};
    vecs[10] = '{1'b0, 3'd5, 16'hFFFF, 16'h00FF, 16'h01A4};
    vecs[11] = '{1'b1, 3'd5, 16'h0000, 16'h00FF, 16'h01A4};
    vecs[12] = '{1'b1, 3'd3, 16'h0000, 16'h00FF, 16'h01A4};
    vecs[13] = '{1'b0, 3'd4, 16'h5A5A, 16'h00FF, 16'h01A4};
    vecs[14] = '{1'b1, 3'd4, 16'h5A5A, 16'h00FF, 16'h01A4};
    vecs[15] = '{1'b0, 3'd4, 16'h0000, 16'h00FF, 16'h01A4};
    vecs[16] = '{1'b0, 3'd3, 16'h00F0, 16'h00FF, 16'h01A4};
    vecs[17] = '{1'b1, 3'd3, 16'h00F0, 16'h00FF, 16'h01A4};
    vecs[18] = '{1'b0, 3'd3, 16'h0000, 16'h00FF, 16'h01A4};

    // Power-on reset
    #2 rst_n = 1'b0;
    cyc(2);
    chk_outputs_zero("por");
    rst_n = 1'b1;
    cyc(1);

    // Register table with GPIO pad checks
    for (int i = 0; i < 19; i++) begin
      if (vecs[i].rd) begin
        rd(vecs[i].a, vecs[i].data, $sformatf("vec%0d_rdata", i));
      end else begin
        wr(vecs[i].a, vecs[i].data);
        chk($sformatf("vec%0d_rvalid_idle", i), 32'(rvalid), 32'd0);
      end
      chk($sformatf("vec%0d_pin_oe", i),  32'(pin_oe),  32'(vecs[i].oe));
      chk($sformatf("vec%0d_pin_out", i), 32'(pin_out), 32'(vecs[i].out));
    end

    // Mux: pin 2 ALT_IN, pin 3 ALT_OUT
    wr(3'd0, 16'h0000);
    wr(3'd1, 16'h0000);
    pinsel = 32'h0000_0090;
    pin_in = 16'h0004;
    cyc(1);
    chk("altin_lat1", 32'(alt_in), 32'h0);
    cyc(1);
    chk("altin_lat2", 32'(alt_in), 32'h4);
    alt_out = 16'h0008; #1;
    chk("altout_out", 32'(pin_out), 32'h8);
    chk("altout_oe",  32'(pin_oe),  32'h8);
    alt_out = 16'hFFFF; #1;
    chk("altout_only_pin3", 32'(pin_out), 32'h8);
    alt_out = 16'h0000; #1;
    chk("altout_low", 32'(pin_out), 32'h0);
    pin_in = 16'h000C;
    cyc(3);
    chk("altin_only_pin2", 32'(alt_in), 32'h4);
    pin_in = '0; pinsel = '0;
    cyc(3);
    chk("altin_gpio_zero", 32'(alt_in), 32'h0);

    // Rising IRQ on pin 0 with cycle-exact latency
    pinsel = 32'h0000_0003;
    wr(3'd4, 16'h0000);
    wr(3'd3, 16'h0001);
    pin_in = 16'h0001;
    cyc(2);
    chk("rise_irq_e2", 32'(irq), 32'd0);
    rd_en = 1'b1; addr = 3'd5;
    @(negedge clk);
    chk("rise_pend_e3", 32'(rdata), 32'h0);
    chk("rise_irq_e3",  32'(irq),   32'd0);
    @(negedge clk);
    rd_en = 1'b0;
    chk("rise_pend_e4",   32'(rdata),  32'h1);
    chk("rise_rvalid_e4", 32'(rvalid), 32'd1);
    chk("rise_irq_e4",    32'(irq),    32'd1);
    pinsel = '0;
    rd(3'd5, 16'h0001, "pend_sticky_fsel");
    wr(3'd5, 16'h0001);
    cyc(1);
    chk("w1c_irq_clear", 32'(irq), 32'd0);
    rd(3'd5, 16'h0000, "w1c_pend_clear");

    // Falling IRQ on pin 1, then W1C colliding with a new set
    pinsel = 32'h0000_000C;
    wr(3'd3, 16'h0002);
    wr(3'd4, 16'h0002);
    pin_in = 16'h0003;
    cyc(4);
    rd(3'd5, 16'h0000, "fall_ignores_rise");
    pin_in = 16'h0001;
    cyc(4);
    chk("fall_irq", 32'(irq), 32'd1);
    rd(3'd5, 16'h0002, "fall_pend");
    wr(3'd5, 16'h0002);
    rd(3'd5, 16'h0000, "fall_w1c");
    pin_in = 16'h0003;
    cyc(4);
    rd(3'd5, 16'h0000, "fall_rise2_ignored");
    pin_in = 16'h0001;
    cyc(2);
    wr(3'd5, 16'h0002);
    rd(3'd5, 16'h0002, "collision_set_wins");
    chk("collision_irq", 32'(irq), 32'd1);
    wr(3'd5, 16'h0002);
    rd(3'd5, 16'h0000, "collision_later_w1c");

    // Gating: pin 0 IRQ mode but disabled, pin 4 enabled but GPIO mode
    pinsel = 32'h0000_0003;
    wr(3'd4, 16'h0000);
    wr(3'd3, 16'h0010);
    pin_in = '0;
    cyc(4);
    wr(3'd5, 16'hFFFF);
    pin_in = 16'h0011;
    cyc(2);
    rd(3'd2, 16'h0011, "gate_din");
    cyc(3);
    rd(3'd5, 16'h0000, "gate_pend");
    chk("gate_irq", 32'(irq), 32'd0);

    // Asynchronous reset in the middle of a read with interrupts pending
    wr(3'd3, 16'h0001);
    pin_in = '0;
    cyc(4);
    pin_in = 16'h0001;
    cyc(5);
    chk("pre_rst_irq", 32'(irq), 32'd1);
    pinsel = '0;
    wr(3'd0, 16'hFFFF);
    wr(3'd1, 16'hFFFF);
    chk("pre_rst_pin_out", 32'(pin_out), 32'hFFFF);
    rd_en = 1'b1; addr = 3'd1;
    @(posedge clk); #1;
    chk("midread_rvalid", 32'(rvalid), 32'd1);
    chk("midread_rdata",  32'(rdata),  32'hFFFF);
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("async_rst");
    @(negedge clk);
    rd_en = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    cyc(1);
    rd(3'd0, 16'h0000, "post_rst_dir");
    rd(3'd1, 16'h0000, "post_rst_dout");
    rd(3'd5, 16'h0000, "post_rst_pend");
    chk("post_rst_irq", 32'(irq), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
